// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-address
// width, FSM state encoding and the per-stage control bundle with its
// canonical output patterns.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 2;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_FLUSH    = 2'd1,
        HZ_MEM_WAIT = 2'd2,
        HZ_HALTED   = 2'd3
    } hz_state_e;

    // Stage controls driven toward the PC and pipeline registers
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_bubble;
        logic mem_stall;
        logic halted;
    } hz_ctrl_t;

    // Held in reset: nothing loads, every stage is cleared
    localparam hz_ctrl_t CTRL_RESET = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
        id_ex_write: 1'b0, id_ex_bubble: 1'b1, ex_mem_write: 1'b0,
        mem_wb_bubble: 1'b1, mem_stall: 1'b0, halted: 1'b0};

    // Free-flowing pipeline
    localparam hz_ctrl_t CTRL_RUN = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
        id_ex_write: 1'b1, id_ex_bubble: 1'b0, ex_mem_write: 1'b1,
        mem_wb_bubble: 1'b0, mem_stall: 1'b0, halted: 1'b0};

    // Memory not ready: everything upstream of MEM/WB holds
    localparam hz_ctrl_t CTRL_FREEZE = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
        id_ex_write: 1'b0, id_ex_bubble: 1'b0, ex_mem_write: 1'b0,
        mem_wb_bubble: 1'b1, mem_stall: 1'b1, halted: 1'b0};

    // Redirect: fetch the target, squash IF/ID and ID/EX
    localparam hz_ctrl_t CTRL_FLUSH = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
        id_ex_write: 1'b1, id_ex_bubble: 1'b1, ex_mem_write: 1'b1,
        mem_wb_bubble: 1'b0, mem_stall: 1'b0, halted: 1'b0};

    // Load-use: hold PC and IF/ID, insert one bubble into EX
    localparam hz_ctrl_t CTRL_LOADUSE = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
        id_ex_write: 1'b1, id_ex_bubble: 1'b1, ex_mem_write: 1'b1,
        mem_wb_bubble: 1'b0, mem_stall: 1'b0, halted: 1'b0};

    // Halted: front end stopped, back end keeps draining
    localparam hz_ctrl_t CTRL_HALT = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
        id_ex_write: 1'b1, id_ex_bubble: 1'b1, ex_mem_write: 1'b1,
        mem_wb_bubble: 1'b0, mem_stall: 1'b0, halted: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator. Flags an ID instruction
// that reads the destination of a load still sitting in ID/EX.
//   ex_mem_read_i, ex_rd_i             : load in ID/EX and its destination
//   id_valid_i, id_rs_i, id_rt_i,
//   id_uses_rs_i, id_uses_rt_i         : ID instruction source operands
//   loaduse_o                          : stall required (combinational)
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rs_i,
    input  logic                  id_uses_rt_i,
    output logic                  loaduse_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit    = id_uses_rs_i && (id_rs_i == ex_rd_i);
    assign rt_hit    = id_uses_rt_i && (id_rt_i == ex_rd_i);
    assign loaduse_o = ex_mem_read_i && id_valid_i && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage core.
// Handles load-use, taken-redirect flush, data-memory wait and HLT drain.
// Outputs are decoded combinationally from the state register and inputs.
//   clk, reset_n                  : clock, async active-low reset
//   id_* / ex_* / dmem_*          : hazard sources from ID, EX and MEM
//   pc_write .. mem_wb_bubble     : per-stage write-enable/flush/bubble
//   mem_stall, halted             : status
//   stall_cycles                  : saturating stall counter, present only
//                                   when HAZARD_PERF_COUNTER_EN is defined
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned PERF_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_halt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_redirect,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_write,
    output logic                  mem_wb_bubble,
    output logic                  mem_stall,
`ifdef HAZARD_PERF_COUNTER_EN
    output logic [PERF_W-1:0]     stall_cycles,
`endif
    output logic                  halted
);

    // Elaboration-time parameter sanity
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be 1..3");
    end
    if (PERF_W == 0) begin : g_bad_perf_w
        $error("PERF_W must be non-zero");
    end

    localparam logic [1:0] FLUSH_INIT  = 2'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    hz_state_e  state_q, state_d;
    logic [1:0] flush_cnt_q, flush_cnt_d;
    logic       resume_flush_q, resume_flush_d;
    hz_ctrl_t   ctrl;
    hz_ctrl_t   ctrl_out;
    logic       memwait;
    logic       loaduse;
    logic       eval_run;
    logic       eval_flush;

    assign memwait = dmem_req && !dmem_ready;

    hazard_detect u_hazard_detect (
        .ex_mem_read_i (ex_mem_read),
        .ex_rd_i       (ex_rd),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rs_i  (id_uses_rs),
        .id_uses_rt_i  (id_uses_rt),
        .loaduse_o     (loaduse)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= HZ_RUN;
            flush_cnt_q    <= 2'd0;
            resume_flush_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            resume_flush_q <= resume_flush_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        resume_flush_d = resume_flush_q;
        ctrl           = CTRL_RUN;
        eval_run       = 1'b0;
        eval_flush     = 1'b0;

        case (state_q)
            HZ_RUN: begin
                if (memwait) begin
                    ctrl           = CTRL_FREEZE;
                    state_d        = HZ_MEM_WAIT;
                    resume_flush_d = 1'b0;
                end else begin
                    eval_run = 1'b1;
                end
            end
            HZ_FLUSH: begin
                // Flush count is held across the wait and resumed after it
                if (memwait) begin
                    ctrl           = CTRL_FREEZE;
                    state_d        = HZ_MEM_WAIT;
                    resume_flush_d = 1'b1;
                end else begin
                    eval_flush = 1'b1;
                end
            end
            HZ_MEM_WAIT: begin
                // Release cycle is decoded as if the wait never happened
                if (memwait) begin
                    ctrl = CTRL_FREEZE;
                end else begin
                    resume_flush_d = 1'b0;
                    eval_flush     = resume_flush_q;
                    eval_run       = !resume_flush_q;
                end
            end
            HZ_HALTED: begin
                ctrl        = memwait ? CTRL_FREEZE : CTRL_HALT;
                ctrl.halted = 1'b1;
            end
            default: begin
                state_d = HZ_RUN;
            end
        endcase

        if (eval_flush) begin
            ctrl = CTRL_FLUSH;
            if (flush_cnt_q <= 2'd1) begin
                state_d     = HZ_RUN;
                flush_cnt_d = 2'd0;
            end else begin
                state_d     = HZ_FLUSH;
                flush_cnt_d = 2'(flush_cnt_q - 2'd1);
            end
        end else if (eval_run) begin
            state_d = HZ_RUN;
            // Redirect beats load-use: the dependent ID instruction is squashed
            if (ex_redirect) begin
                ctrl = CTRL_FLUSH;
                if (MULTI_FLUSH) begin
                    state_d     = HZ_FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                end
            end else if (loaduse) begin
                ctrl = CTRL_LOADUSE;
            end else if (id_halt && id_valid) begin
                state_d = HZ_HALTED;
            end
        end
    end

    // Reset forces the clearing pattern regardless of state
    assign ctrl_out      = reset_n ? ctrl : CTRL_RESET;
    assign pc_write      = ctrl_out.pc_write;
    assign if_id_write   = ctrl_out.if_id_write;
    assign if_id_flush   = ctrl_out.if_id_flush;
    assign id_ex_write   = ctrl_out.id_ex_write;
    assign id_ex_bubble  = ctrl_out.id_ex_bubble;
    assign ex_mem_write  = ctrl_out.ex_mem_write;
    assign mem_wb_bubble = ctrl_out.mem_wb_bubble;
    assign mem_stall     = ctrl_out.mem_stall;
    assign halted        = ctrl_out.halted;

`ifdef HAZARD_PERF_COUNTER_EN
    logic [PERF_W-1:0] stall_cycles_q;

    // Saturating count of stalled-PC cycles outside HALTED
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
        end else if (!pc_write && (state_q != HZ_HALTED)
                     && (stall_cycles_q != {PERF_W{1'b1}})) begin
            stall_cycles_q <= stall_cycles_q + PERF_W'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: three controllers (FLUSH_CYCLES 1, 2, 3) share one
// stimulus stream and are compared every cycle against a behavioural model
// that tracks only "halted" and "flush cycles still owed".
module tb_pipeline_hazard_ctrl;

    // Control pattern order:
    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
    //  ex_mem_write, mem_wb_bubble, mem_stall, halted}
    localparam logic [8:0] P_RESET   = 9'b001010100;
    localparam logic [8:0] P_RUN     = 9'b110101000;
    localparam logic [8:0] P_FREEZE  = 9'b000000110;
    localparam logic [8:0] P_FLUSH   = 9'b111111000;
    localparam logic [8:0] P_LOADUSE = 9'b000111000;
    localparam logic [8:0] P_HALT    = 9'b000111001;
    localparam int         CNT_MAX   = 15;

    logic       clk;
    logic       reset_n;
    logic       id_valid, id_uses_rs, id_uses_rt, id_halt;
    logic [1:0] id_rs, id_rt, ex_rd;
    logic       ex_mem_read, ex_redirect, dmem_req, dmem_ready;

    logic [2:0][8:0] obs;
    logic [2:0][8:0] snap;
`ifdef HAZARD_PERF_COUNTER_EN
    logic [2:0][3:0] stall_obs;
    logic [2:0][3:0] stall_snap;
`endif

    int total = 0;
    int bad   = 0;

    bit m_halted [3];
    int m_rem    [3];
    int m_cnt    [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipeline_hazard_ctrl #(.FLUSH_CYCLES(g + 1), .PERF_W(4)) u_dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .id_valid      (id_valid),
            .id_rs         (id_rs),
            .id_rt         (id_rt),
            .id_uses_rs    (id_uses_rs),
            .id_uses_rt    (id_uses_rt),
            .id_halt       (id_halt),
            .ex_mem_read   (ex_mem_read),
            .ex_rd         (ex_rd),
            .ex_redirect   (ex_redirect),
            .dmem_req      (dmem_req),
            .dmem_ready    (dmem_ready),
            .pc_write      (obs[g][8]),
            .if_id_write   (obs[g][7]),
            .if_id_flush   (obs[g][6]),
            .id_ex_write   (obs[g][5]),
            .id_ex_bubble  (obs[g][4]),
            .ex_mem_write  (obs[g][3]),
            .mem_wb_bubble (obs[g][2]),
            .mem_stall     (obs[g][1]),
`ifdef HAZARD_PERF_COUNTER_EN
            .stall_cycles  (stall_obs[g]),
`endif
            .halted        (obs[g][0])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected controls for instance k (FLUSH_CYCLES = k+1) from current inputs
    function automatic void model(input int k, output logic [8:0] e,
                                  output bit nh, output int nr);
        bit mw;
        bit lu;
        mw = dmem_req && !dmem_ready;
        lu = ex_mem_read && id_valid &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        nh = m_halted[k];
        nr = m_rem[k];
        if (m_halted[k])           e = mw ? (P_FREEZE | 9'b1) : P_HALT;
        else if (mw)               e = P_FREEZE;
        else if (m_rem[k] > 0)     begin e = P_FLUSH; nr = m_rem[k] - 1; end
        else if (ex_redirect)      begin e = P_FLUSH; nr = k; end
        else if (lu)               e = P_LOADUSE;
        else if (id_halt && id_valid) begin e = P_RUN; nh = 1'b1; end
        else                       e = P_RUN;
    endfunction

    task automatic idle();
        id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_halt = 0;
        id_rs = 0; id_rt = 0; ex_rd = 0; ex_mem_read = 0;
        ex_redirect = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    // One clock: check at negedge, advance the model at posedge
    task automatic step();
        logic [8:0] e;
        bit nh [3];
        int nr [3];
        bit inc [3];
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            model(k, e, nh[k], nr[k]);
            inc[k] = !e[8] && !m_halted[k];
            snap[k] = obs[k];
            check($sformatf("ctl%0d", k + 1), 32'(obs[k]), 32'(e));
`ifdef HAZARD_PERF_COUNTER_EN
            stall_snap[k] = stall_obs[k];
            check($sformatf("stall%0d", k + 1), 32'(stall_obs[k]), 32'(m_cnt[k]));
`endif
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            m_halted[k] = nh[k];
            m_rem[k]    = nr[k];
            if (inc[k] && m_cnt[k] < CNT_MAX) m_cnt[k]++;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_ctl%0d", k + 1), 32'(obs[k]), 32'(P_RESET));
`ifdef HAZARD_PERF_COUNTER_EN
            check($sformatf("rst_stall%0d", k + 1), 32'(stall_obs[k]), 32'd0);
`endif
            m_halted[k] = 1'b0;
            m_rem[k]    = 0;
            m_cnt[k]    = 0;
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic set_loaduse();
        id_valid = 1; ex_mem_read = 1; ex_rd = 2'd2; id_rs = 2'd2; id_uses_rs = 1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        do_reset();
        step();
        check("run_idle", 32'(snap[0]), 32'(P_RUN));

        // Load-use: exactly one bubble, then defaults; no stall if rs unused
        set_loaduse();
        step();
        check("lu_stall", 32'(snap[0]), 32'(P_LOADUSE));
        ex_mem_read = 0;
        step();
        check("lu_after", 32'(snap[0]), 32'(P_RUN));
        ex_mem_read = 1; id_uses_rs = 0;
        step();
        check("lu_unused", 32'(snap[0]), 32'(P_RUN));
        idle();
        repeat (3) step();

        // Redirect with simultaneous load-use: redirect wins
        set_loaduse();
        ex_redirect = 1;
        step();
        check("rd_c0_fc2", 32'(snap[1]), 32'(P_FLUSH));
        idle();
        step();
        check("rd_c1_fc1", 32'(snap[0]), 32'(P_RUN));
        check("rd_c1_fc2", 32'(snap[1]), 32'(P_FLUSH));
        check("rd_c1_fc3", 32'(snap[2]), 32'(P_FLUSH));
        step();
        check("rd_c2_fc2", 32'(snap[1]), 32'(P_RUN));
        check("rd_c2_fc3", 32'(snap[2]), 32'(P_FLUSH));
        step();
        check("rd_c3_fc3", 32'(snap[2]), 32'(P_RUN));

        // Memory wait 3 cycles; redirect raised mid-wait acts on release
        dmem_req = 1; dmem_ready = 0;
        step();
        check("mw_c0", 32'(snap[0]), 32'(P_FREEZE));
        ex_redirect = 1;
        step();
        check("mw_c1", 32'(snap[0]), 32'(P_FREEZE));
        step();
        check("mw_c2", 32'(snap[0]), 32'(P_FREEZE));
        dmem_ready = 1;
        step();
        check("mw_release", 32'(snap[0]), 32'(P_FLUSH));
        idle();
        repeat (4) step();

        // Wait entered during FLUSH (FLUSH_CYCLES=3, two flush cycles owed)
        ex_redirect = 1;
        step();
        ex_redirect = 0; dmem_req = 1; dmem_ready = 0;
        step();
        check("wf_frz0", 32'(snap[2]), 32'(P_FREEZE));
        step();
        check("wf_frz1", 32'(snap[2]), 32'(P_FREEZE));
        dmem_req = 0;
        step();
        check("wf_fl0", 32'(snap[2]), 32'(P_FLUSH));
        step();
        check("wf_fl1", 32'(snap[2]), 32'(P_FLUSH));
        step();
        check("wf_run", 32'(snap[2]), 32'(P_RUN));

        // Halt: sticky until reset, memwait freezes inside HALTED
        id_halt = 1; id_valid = 1;
        step();
        idle();
        step();
        check("halt_c1", 32'(snap[0]), 32'(P_HALT));
        set_loaduse(); ex_redirect = 1;
        step();
        check("halt_c2", 32'(snap[1]), 32'(P_HALT));
        idle(); dmem_req = 1;
        step();
        check("halt_frz", 32'(snap[0]), 32'(P_FREEZE | 9'b1));
        idle();
        step();
        do_reset();
        step();
        check("halt_rst", 32'(snap[0]), 32'(P_RUN));

`ifdef HAZARD_PERF_COUNTER_EN
        // Stall counter saturation
        do_reset();
        set_loaduse();
        repeat (20) step();
        step();
        check("perf_sat", 32'(stall_snap[0]), 32'd15);
        idle();
        do_reset();
`endif

        // Randomised traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rs       = 2'($urandom_range(0, 3));
            id_rt       = 2'($urandom_range(0, 3));
            id_uses_rs  = 1'($urandom_range(0, 1));
            id_uses_rt  = 1'($urandom_range(0, 1));
            id_halt     = ($urandom_range(0, 29) == 0);
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_rd       = 2'($urandom_range(0, 3));
            ex_redirect = ($urandom_range(0, 6) == 0);
            dmem_req    = ($urandom_range(0, 2) == 0);
            dmem_ready  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) do_reset();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipelined core, companion to the EX-stage forwarding logic.
- Detects hazards forwarding cannot cover:
  - load-use
  - taken branch/jump redirect
  - data-memory wait
  - HLT drain
- Drives the per-stage write-enable, flush and bubble controls of the PC and pipeline registers.
- One registered FSM plus a flush counter; outputs are decoded combinationally from state and inputs.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles IF/ID is flushed after a redirect (1..3).
- PERF_W, 16, width of the stall performance counter (optional feature only).

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs  in  2  rs field of the ID instruction.
- id_rt  in  2  rt field of the ID instruction.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_halt  in  1  ID instruction is HLT.
- ex_mem_read  in  1  ID/EX instruction is a load.
- ex_rd  in  2  destination register of the ID/EX instruction.
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle.
- dmem_req  in  1  MEM stage is issuing a data access.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID cleared to NOP on the next edge.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_bubble  out  1  ID/EX loads a NOP (control bits zero).
- ex_mem_write  out  1  EX/MEM load enable.
- mem_wb_bubble  out  1  MEM/WB loads a NOP.
- mem_stall  out  1  pipeline frozen on memory.
- halted  out  1  HLT retired; core stopped.

Behaviour:
- States: RUN, FLUSH, MEM_WAIT, HALTED; state encoding is 2 bits. flush_cnt is 2 bits. resume_flush is 1 bit.
- Reset (reset_n low, asynchronous):
  - state=RUN, flush_cnt=0, resume_flush=0.
  - While low: pc_write, if_id_write, id_ex_write and ex_mem_write are 0; if_id_flush, id_ex_bubble and mem_wb_bubble are 1; mem_stall=0, halted=0.
- Default outputs (RUN, no event): all write enables 1; flush, bubble and mem_stall 0.
- Definitions:
  - memwait = dmem_req & !dmem_ready.
  - loaduse = ex_mem_read & id_valid & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- RUN, priority highest first:
  1. memwait:
     - All four write enables 0, mem_wb_bubble=1, mem_stall=1.
     - Next state MEM_WAIT, resume_flush=0.
  2. ex_redirect:
     - pc_write=1, if_id_flush=1, id_ex_bubble=1.
     - If FLUSH_CYCLES>1: next FLUSH, flush_cnt=FLUSH_CYCLES-1. Otherwise stay RUN.
  3. loaduse:
     - pc_write=0, if_id_write=0, id_ex_bubble=1.
     - Exactly one bubble; stay RUN. The load advances, so loaduse clears next cycle.
  4. id_halt & id_valid:
     - Default outputs this cycle; next HALTED.
- FLUSH:
  - if_id_flush=1, id_ex_bubble=1, pc_write=1.
  - flush_cnt decrements; at 1, next RUN.
  - memwait takes priority: freeze as in RUN item 1, set resume_flush=1, flush_cnt held.
  - loaduse and id_halt are ignored (ID holds a NOP).
- MEM_WAIT:
  - Freeze outputs every cycle while memwait.
  - ex_redirect and loaduse are ignored while frozen; the EX/ID contents are held and re-evaluated after release.
  - When dmem_ready=1 (or dmem_req drops): evaluate exactly as RUN items 2-4 in the same cycle, or as FLUSH if resume_flush=1. Clear resume_flush.
- HALTED:
  - pc_write=0, if_id_write=0, id_ex_bubble=1, halted=1.
  - Downstream stages keep draining (id_ex_write, ex_mem_write=1).
  - memwait still freezes without leaving HALTED.
  - Exit only via reset.
- Simultaneous ex_redirect and loaduse: redirect wins. The ID instruction is flushed, so no stall.
- Reset mid-MEM_WAIT or mid-FLUSH: immediate return to RUN with reset outputs; no resume.

Optional Feature:
- Macro HAZARD_PERF_COUNTER_EN.
- Defined:
  - Adds output stall_cycles [PERF_W-1:0], cleared by reset.
  - Increments by 1 on each rising edge where pc_write=0 and state!=HALTED.
  - Saturates at all-ones; no wrap.
- Undefined: port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package/header: state encodings (HZ_RUN=0, HZ_FLUSH=1, HZ_MEM_WAIT=2, HZ_HALTED=3) and register-address width (2), alongside the existing opcode definitions.
- Sub-module hazard_detect: purely combinational loaduse comparator. It is natural to separate and reusable by a future ID-stage forwarding unit.
- The FSM stays in pipeline_hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=2, id_rs=2, id_uses_rs=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 exactly 1 cycle; next cycle (ex_mem_read=0) defaults; no stall when id_uses_rs=0.
- Redirect, FLUSH_CYCLES=2: ex_redirect pulse at cycle 10 -> if_id_flush=1 at cycles 10 and 11, RUN at 12; same cycle loaduse=1 -> pc_write=1 (redirect wins).
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> mem_stall=1 and all write enables 0 for 3 cycles; 4th cycle defaults; ex_redirect asserted during wait is acted on only in the release cycle.
- Wait during flush, FLUSH_CYCLES=3: memwait 2 cycles entered at flush_cnt=2 -> after release, 2 further if_id_flush cycles, then RUN.
- Halt: id_halt=1, id_valid=1 -> next cycle halted=1, pc_write=0 permanently; reset_n low for 1 cycle mid-HALTED -> halted=0, RUN restored.
- HAZARD_PERF_COUNTER_EN, PERF_W=4: 20 stall cycles -> stall_cycles=15 (saturated); reset -> 0.
